// File: rtl/conv1_relu_out_writeback_if.sv
// conv1 writeback bus: upstream BN results and halt, BRAM write port, status.
// Ports: master = producer/observer side, slave = conv1_relu_out_writeback.
interface conv1_relu_out_writeback_if #(
    parameter int CH_NUM = 64,
    parameter int DW     = 16,
    parameter int OUT_W  = 256,
    parameter int ADDR_W = 16
);
    logic                   start;
    logic [CH_NUM*DW-1:0]   bn_res;
    logic                   bn_res_v;
    logic                   halt;
    logic                   wr_en;
    logic [ADDR_W-1:0]      wr_addr;
    logic [OUT_W-1:0]       wr_data;
    logic                   frame_done;
    logic                   ovf_err;

    modport master (
        output start, bn_res, bn_res_v,
        input  halt, wr_en, wr_addr, wr_data, frame_done, ovf_err
    );

    modport slave (
        input  start, bn_res, bn_res_v,
        output halt, wr_en, wr_addr, wr_data, frame_done, ovf_err
    );
endinterface

// File: rtl/conv1_relu_out_writeback.sv
// conv1 output writeback: ReLU/shift/clamp, pixel FIFO, beat serialiser to BRAM.
// Ports: clk, rst (async active-low), bus (slave: bn_res in, halt/wr_*/status out).
module conv1_relu_out_writeback #(
    parameter int CH_NUM     = 64,
    parameter int DW         = 16,
    parameter int OUT_W      = 256,
    parameter int OUT_PIX    = 12544,
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int SHIFT      = 0,
    parameter int CLAMP_MAX  = 32767
) (
    input  logic clk,
    input  logic rst,
    conv1_relu_out_writeback_if.slave bus
);
    localparam int PW    = CH_NUM * DW;
    localparam int BEATS = PW / OUT_W;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW    = AW + 1;
    localparam logic [DW-1:0] CMAX = DW'(CLAMP_MAX);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      relu_w;
    logic [PW-1:0]      s1_q, s1_d;
    logic               s1_v_q, s1_v_d;
    logic [PW-1:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CW:0]        occ;
    logic [BW-1:0]      beat_q, beat_d;
    logic [ADDR_W-1:0]  pix_q, pix_d;
    logic               wr_en_q, wr_en_d, fd_q, fd_d, ovf_q, ovf_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [OUT_W-1:0]   data_q, data_d;
    logic [OUT_W-1:0]   beat_w [BEATS];
    logic [PW-1:0]      head;
    logic               halt_w, accept, push, pop, emit, last;

    // Negative inputs are zeroed first, so a logical shift matches >>>.
    for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
        logic [DW-1:0] x, y;
        assign x = bus.bn_res[k*DW +: DW];
        assign y = x >> SHIFT;
        assign relu_w[k*DW +: DW] = x[DW-1] ? '0 : (y > CMAX) ? CMAX : y;
    end

    assign head = mem_q[rptr_q];
    for (genvar b = 0; b < BEATS; b++) begin : g_beat
        assign beat_w[b] = head[b*OUT_W +: OUT_W];
    end

    // Counting the in-flight stage-1 word reserves its FIFO slot up front.
    assign occ    = {1'b0, cnt_q} + (CW+1)'(s1_v_q);
    assign halt_w = occ >= (CW+1)'(FIFO_DEPTH);
    assign accept = bus.bn_res_v & ~halt_w & ~bus.start;
    assign push   = s1_v_q;

    always_comb begin
        s1_d   = accept ? relu_w : s1_q;
        s1_v_d = accept;
        ovf_d  = bus.start ? 1'b0 : (ovf_q | (bus.bn_res_v & halt_w));
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        pix_d   = pix_q;
        wr_en_d = 1'b0;
        fd_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        emit    = 1'b0;
        unique case (state_q)
            S_IDLE: emit = (cnt_q != '0);
            S_SEND: emit = 1'b1;
        endcase
        last = emit && (beat_q == BW'(BEATS - 1));
        pop  = last;
        if (emit) begin
            wr_en_d = 1'b1;
            addr_d  = pix_q * ADDR_W'(BEATS) + ADDR_W'(beat_q);
            data_d  = beat_w[beat_q];
            beat_d  = beat_q + BW'(1);
            state_d = S_SEND;
            if (last) begin
                beat_d  = '0;
                fd_d    = (pix_q == ADDR_W'(OUT_PIX - 1));
                pix_d   = fd_d ? '0 : pix_q + ADDR_W'(1);
                // Continue without a bubble if another pixel remains.
                state_d = ((cnt_q > CW'(1)) || push) ? S_SEND : S_IDLE;
            end
        end
        if (bus.start) begin
            state_d = S_IDLE;
            beat_d  = '0;
            pix_d   = '0;
            wr_en_d = 1'b0;
            fd_d    = 1'b0;
        end
    end

    always_comb begin
        cnt_d  = cnt_q + CW'(push) - CW'(pop);
        wptr_d = wptr_q + AW'(push);
        rptr_d = rptr_q + AW'(pop);
        if (bus.start) begin
            cnt_d  = '0;
            wptr_d = '0;
            rptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= s1_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            s1_q    <= '0;
            s1_v_q  <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            beat_q  <= '0;
            pix_q   <= '0;
            wr_en_q <= 1'b0;
            fd_q    <= 1'b0;
            ovf_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            s1_q    <= s1_d;
            s1_v_q  <= s1_v_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            pix_q   <= pix_d;
            wr_en_q <= wr_en_d;
            fd_q    <= fd_d;
            ovf_q   <= ovf_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign bus.halt       = halt_w;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = addr_q;
    assign bus.wr_data    = data_q;
    assign bus.frame_done = fd_q;
    assign bus.ovf_err    = ovf_q;
endmodule

// File: tb/tb_conv1_relu_out_writeback.sv
// Scoreboard bench for conv1_relu_out_writeback: two instances (plain, shift/clamp).
// Both small-frame (3 pixels), driven by identical stimulus.
module tb_conv1_relu_out_writeback;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv1_relu_out_writeback_if #(.CH_NUM(64), .DW(16), .OUT_W(256), .ADDR_W(16)) ia ();
    conv1_relu_out_writeback_if #(.CH_NUM(64), .DW(16), .OUT_W(256), .ADDR_W(16)) ib ();

    assign ib.start    = ia.start;
    assign ib.bn_res   = ia.bn_res;
    assign ib.bn_res_v = ia.bn_res_v;

    conv1_relu_out_writeback #(
        .OUT_PIX(3), .SHIFT(0), .CLAMP_MAX(32767)
    ) dut_a (.clk(clk), .rst(rst), .bus(ia));

    conv1_relu_out_writeback #(
        .OUT_PIX(3), .SHIFT(2), .CLAMP_MAX(100)
    ) dut_b (.clk(clk), .rst(rst), .bus(ib));

    typedef struct {
        logic [15:0]  addr;
        logic [255:0] data;
        logic         fd;
    } beat_t;

    beat_t qa[$];
    beat_t qb[$];
    beat_t ma, mb;
    int total = 0;
    int bad = 0;
    int pix_m = 0;
    int fd_cnt = 0;
    int n = 0;
    logic halt_seen;
    logic [1023:0] px, ea, eb;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Input pattern (sel=0) and expected outputs for dut_a (1) / dut_b (2).
    function automatic logic [1023:0] pat(input int p, input int sel);
        logic [1023:0] r;
        int v;
        r = '0;
        for (int k = 0; k < 64; k++) begin
            v = (p * 7 + k * 3) % 512;
            if (k == 5) v = -(p + 1);
            if (sel != 0 && v < 0) v = 0;
            if (sel == 2) begin
                v = v >>> 2;
                if (v > 100) v = 100;
            end
            r[k*16 +: 16] = 16'(v);
        end
        return r;
    endfunction

    task automatic push_exp(input logic [1023:0] xa, input logic [1023:0] xb);
        for (int b = 0; b < 4; b++) begin
            qa.push_back('{addr: 16'(pix_m * 4 + b), data: xa[b*256 +: 256],
                           fd: (b == 3 && pix_m == 2)});
            qb.push_back('{addr: 16'(pix_m * 4 + b), data: xb[b*256 +: 256],
                           fd: (b == 3 && pix_m == 2)});
        end
        pix_m = (pix_m + 1) % 3;
    endtask

    // Present one pixel, honouring halt; called at posedge+1.
    task automatic send_exp(input logic [1023:0] p, input logic [1023:0] xa,
                            input logic [1023:0] xb);
        logic done;
        done = 1'b0;
        ia.bn_res = p;
        for (int i = 0; i < 100 && !done; i++) begin
            if (ia.halt) begin
                ia.bn_res_v = 1'b0;
            end else begin
                ia.bn_res_v = 1'b1;
                push_exp(xa, xb);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        ia.bn_res_v = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout act=halt_stuck exp=accept");
        end
    endtask

    task automatic send_pat(input int p);
        send_exp(pat(p, 0), pat(p, 1), pat(p, 2));
    endtask

    task automatic pulse_start();
        ia.start = 1'b1;
        @(posedge clk);
        #1;
        ia.start = 1'b0;
        qa.delete();
        qb.delete();
        pix_m = 0;
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 300; i++) begin
            if (qa.size() == 0 && qb.size() == 0) break;
            @(negedge clk);
        end
        chk(nm, 256'(qa.size() + qb.size()), 256'(0));
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst && ia.wr_en) begin
            if (ia.frame_done) fd_cnt++;
            if (qa.size() == 0) begin
                total++;
                bad++;
                $display("FAIL a_extra_write act=%0d exp=none", ia.wr_addr);
            end else begin
                ma = qa.pop_front();
                chk("a_addr", 256'(ia.wr_addr), 256'(ma.addr));
                chk("a_data", ia.wr_data, ma.data);
                chk("a_fd", 256'(ia.frame_done), 256'(ma.fd));
            end
        end
    end

    always @(negedge clk) begin
        if (rst && ib.wr_en) begin
            if (qb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL b_extra_write act=%0d exp=none", ib.wr_addr);
            end else begin
                mb = qb.pop_front();
                chk("b_addr", 256'(ib.wr_addr), 256'(mb.addr));
                chk("b_data", ib.wr_data, mb.data);
                chk("b_fd", 256'(ib.frame_done), 256'(mb.fd));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        ia.start = 1'b0;
        ia.bn_res = '0;
        ia.bn_res_v = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rst_wr_en", 256'(ia.wr_en), 256'(0));
        chk("rst_addr", 256'(ia.wr_addr), 256'(0));
        chk("rst_data", ia.wr_data, 256'(0));
        chk("rst_fd", 256'(ia.frame_done), 256'(0));
        chk("rst_ovf", 256'(ia.ovf_err), 256'(0));
        chk("rst_halt", 256'(ia.halt), 256'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // 1) ch k = k-32, plus first-write latency.
        for (int k = 0; k < 64; k++) begin
            px[k*16 +: 16] = 16'(k - 32);
            ea[k*16 +: 16] = (k < 32) ? 16'd0 : 16'(k - 32);
            eb[k*16 +: 16] = (k < 32) ? 16'd0 : 16'((k - 32) / 4);
        end
        send_exp(px, ea, eb);
        @(negedge clk);
        chk("lat_e0", 256'(ia.wr_en), 256'(0));
        @(negedge clk);
        chk("lat_e1", 256'(ia.wr_en), 256'(0));
        @(negedge clk);
        chk("lat_e2", 256'(ia.wr_en), 256'(1));
        drain("t1_drain");

        // 2) clamp/shift corner values.
        for (int k = 0; k < 64; k++) begin
            case (k % 4)
                0: begin px[k*16 +: 16] = 16'h7FFF; ea[k*16 +: 16] = 16'h7FFF; eb[k*16 +: 16] = 16'd100; end
                1: begin px[k*16 +: 16] = 16'd400;  ea[k*16 +: 16] = 16'd400;  eb[k*16 +: 16] = 16'd100; end
                2: begin px[k*16 +: 16] = 16'd40;   ea[k*16 +: 16] = 16'd40;   eb[k*16 +: 16] = 16'd10;  end
                default: begin px[k*16 +: 16] = 16'hFFFB; ea[k*16 +: 16] = 16'd0; eb[k*16 +: 16] = 16'd0; end
            endcase
        end
        send_exp(px, ea, eb);
        drain("t2_drain");

        // 3) continuous producer that stalls on halt.
        halt_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ia.halt) begin
                ia.bn_res_v = 1'b0;
                halt_seen = 1'b1;
            end else begin
                ia.bn_res = pat(n, 0);
                ia.bn_res_v = 1'b1;
                push_exp(pat(n, 1), pat(n, 2));
                n++;
            end
            @(posedge clk);
            #1;
        end
        ia.bn_res_v = 1'b0;
        chk("t3_halt_seen", 256'(halt_seen), 256'(1));
        drain("t3_drain");
        chk("t3_ovf", 256'(ia.ovf_err), 256'(0));

        // 4) push while halted -> dropped, sticky ovf_err.
        for (int i = 0; i < 50; i++) begin
            if (ia.halt) break;
            ia.bn_res = pat(n, 0);
            ia.bn_res_v = 1'b1;
            push_exp(pat(n, 1), pat(n, 2));
            n++;
            @(posedge clk);
            #1;
        end
        chk("t4_halt_full", 256'(ia.halt), 256'(1));
        ia.bn_res = pat(99, 0);
        ia.bn_res_v = 1'b1;
        @(posedge clk);
        #1;
        ia.bn_res_v = 1'b0;
        chk("t4_ovf_a", 256'(ia.ovf_err), 256'(1));
        chk("t4_ovf_b", 256'(ib.ovf_err), 256'(1));
        repeat (6) @(posedge clk);
        #1;
        chk("t4_ovf_hold", 256'(ia.ovf_err), 256'(1));
        drain("t4_drain");
        chk("t4_ovf_sticky", 256'(ia.ovf_err), 256'(1));
        pulse_start();
        chk("t4_ovf_clr", 256'(ia.ovf_err), 256'(0));

        // 5) 4 pixels in a 3-pixel frame: done at addr 11, wrap to 0.
        fd_cnt = 0;
        for (int i = 0; i < 4; i++) send_pat(200 + i);
        drain("t5_drain");
        chk("t5_fd_count", 256'(fd_cnt), 256'(1));

        // 6) start at beat 2, with a coincident valid that must vanish.
        send_pat(300);
        repeat (4) @(posedge clk);
        #1;
        chk("t6_beat2", 256'(ia.wr_addr), 256'(6));
        ia.bn_res = pat(301, 0);
        ia.bn_res_v = 1'b1;
        pulse_start();
        ia.bn_res_v = 1'b0;
        @(negedge clk);
        chk("t6_wr_en", 256'(ia.wr_en), 256'(0));
        chk("t6_halt", 256'(ia.halt), 256'(0));
        chk("t6_ovf", 256'(ia.ovf_err), 256'(0));
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1;
        send_pat(302);
        drain("t6_drain");

        // Async reset mid-burst.
        send_pat(400);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("ar_wr_en", 256'(ia.wr_en), 256'(0));
        chk("ar_addr", 256'(ia.wr_addr), 256'(0));
        chk("ar_data", ia.wr_data, 256'(0));
        chk("ar_fd", 256'(ia.frame_done), 256'(0));
        chk("ar_b_data", ib.wr_data, 256'(0));
        qa.delete();
        qb.delete();
        pix_m = 0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        send_pat(401);
        drain("ar_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
